// File: rtl/switch_debouncer_pkg.sv
// Shared types and defaults for the switch debouncer: FSM state encoding and the
// default qualification length.
package switch_debouncer_pkg;

  typedef enum logic [1:0] {
    StIdleLow  = 2'd0,
    StWaitHigh = 2'd1,
    StIdleHigh = 2'd2,
    StWaitLow  = 2'd3
  } state_e;

  localparam int unsigned DefaultDebounceCycles = 16;
  localparam int unsigned DefaultSyncStages     = 2;

endpackage

// File: rtl/switch_debouncer_sync_ff.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
// q is the last stage of the chain.
module switch_debouncer_sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/switch_debouncer.sv
// Debounces a bouncy switch input into a registered clean level with one-cycle
// change/rise/fall strobes and a busy flag while a change is being qualified.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned SYNC_STAGES     = DefaultSyncStages
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic clean_d,
  output logic en_pulse,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // cnt holds the number of agreeing samples already seen; the current sample is the last one.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic             sync_s;
  state_e           state;
  logic [CNT_W-1:0] cnt;

  switch_debouncer_sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (raw_in),
    .q    (sync_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= StIdleLow;
      cnt      <= '0;
      clean_d  <= 1'b0;
      en_pulse <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      en_pulse <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      unique case (state)
        StIdleLow: begin
          if (!sync_s) begin
            cnt <= '0;
          end else if (DEBOUNCE_CYCLES == 1) begin
            state    <= StIdleHigh;
            cnt      <= '0;
            clean_d  <= 1'b1;
            en_pulse <= 1'b1;
            rise     <= 1'b1;
          end else begin
            state <= StWaitHigh;
            cnt   <= CntOne;
            busy  <= 1'b1;
          end
        end
        StWaitHigh: begin
          if (!sync_s) begin
            state <= StIdleLow;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt >= CntLast) begin
            state    <= StIdleHigh;
            cnt      <= '0;
            busy     <= 1'b0;
            clean_d  <= 1'b1;
            en_pulse <= 1'b1;
            rise     <= 1'b1;
          end else begin
            cnt <= cnt + CntOne;
          end
        end
        StIdleHigh: begin
          if (sync_s) begin
            cnt <= '0;
          end else if (DEBOUNCE_CYCLES == 1) begin
            state    <= StIdleLow;
            cnt      <= '0;
            clean_d  <= 1'b0;
            en_pulse <= 1'b1;
            fall     <= 1'b1;
          end else begin
            state <= StWaitLow;
            cnt   <= CntOne;
            busy  <= 1'b1;
          end
        end
        StWaitLow: begin
          if (sync_s) begin
            state <= StIdleHigh;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt >= CntLast) begin
            state    <= StIdleLow;
            cnt      <= '0;
            busy     <= 1'b0;
            clean_d  <= 1'b0;
            en_pulse <= 1'b1;
            fall     <= 1'b1;
          end else begin
            cnt <= cnt + CntOne;
          end
        end
        default: begin
          state <= StIdleLow;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer (DEBOUNCE_CYCLES=4, SYNC_STAGES=2), including a
// behavioural d-latch fed by clean_d/en_pulse.
module tb_switch_debouncer;

  logic clk;
  logic reset;
  logic raw_in;
  logic clean_d;
  logic en_pulse;
  logic rise;
  logic fall;
  logic busy;
  logic latch_q;
  logic latch_qbar;

  int n_checks = 0;
  int n_pass   = 0;

  switch_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .raw_in  (raw_in),
    .clean_d (clean_d),
    .en_pulse(en_pulse),
    .rise    (rise),
    .fall    (fall),
    .busy    (busy)
  );

  // Downstream transparent latch: enable = en_pulse, d = clean_d.
  always_latch begin
    if (en_pulse) latch_q <= clean_d;
  end
  assign latch_qbar = ~latch_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_strobes(input string tag);
    check_bit({tag, "_en_is_or"}, en_pulse, rise | fall);
    check_bit({tag, "_not_both"}, rise & fall, 1'b0);
  endtask

  initial begin
    int  en_cnt;
    logic busy_seen;

    reset  = 1'b1;
    raw_in = 1'b1;

    // 1: reset held for 3 edges with raw_in high
    for (int i = 1; i <= 3; i++) begin
      step();
      check_bit("rst_clean", clean_d, 1'b0);
      check_bit("rst_en", en_pulse, 1'b0);
      check_bit("rst_busy", busy, 1'b0);
    end

    // 2: clean rise, accept on edge 6 after release, busy on edges 3..5
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      check_bit("rise_busy", busy, (i >= 3 && i <= 5));
      check_bit("rise_en", en_pulse, i == 6);
      check_bit("rise_rise", rise, i == 6);
      check_bit("rise_fall", fall, 1'b0);
      check_bit("rise_clean", clean_d, i >= 6);
    end

    // back to low via reset
    reset  = 1'b1;
    raw_in = 1'b0;
    step();
    step();
    reset = 1'b0;

    // 3: glitch of 3 cycles rejected
    en_cnt    = 0;
    busy_seen = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      raw_in = (i <= 3);
      step();
      en_cnt += int'(en_pulse);
      busy_seen |= busy;
    end
    check_int("glitch_en_cnt", en_cnt, 0);
    check_bit("glitch_busy_seen", busy_seen, 1'b1);
    check_bit("glitch_busy_end", busy, 1'b0);
    check_bit("glitch_clean", clean_d, 1'b0);

    // boundary: exactly 4 samples accepted, then a clean fall
    en_cnt = 0;
    for (int i = 1; i <= 14; i++) begin
      raw_in = (i <= 4);
      step();
      en_cnt += int'(en_pulse);
      check_bit("exact_rise", rise, i == 6);
      check_bit("exact_fall", fall, i == 10);
      check_strobes("exact");
    end
    check_int("exact_en_cnt", en_cnt, 2);
    check_bit("exact_clean", clean_d, 1'b0);

    // 4: bounce 1,0,1,1,0 then 1 steady -> single rise on edge 11
    en_cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      raw_in = !(i == 2 || i == 5);
      step();
      en_cnt += int'(en_pulse);
      check_bit("bounce_rise", rise, i == 11);
      check_bit("bounce_fall", fall, 1'b0);
    end
    check_int("bounce_en_cnt", en_cnt, 1);
    check_bit("bounce_clean", clean_d, 1'b1);

    // 5: fall qualification aborted by reset two cycles into WAIT_LOW
    raw_in = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check_bit("fallrst_busy", busy, i >= 3);
      check_bit("fallrst_clean", clean_d, 1'b1);
    end
    reset = 1'b1;
    step();
    check_bit("fallrst_rst_clean", clean_d, 1'b0);
    check_bit("fallrst_rst_en", en_pulse, 1'b0);
    check_bit("fallrst_rst_fall", fall, 1'b0);
    check_bit("fallrst_rst_busy", busy, 1'b0);
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      check_bit("fallrst_after_en", en_pulse, 1'b0);
      check_bit("fallrst_after_busy", busy, 1'b0);
      check_bit("fallrst_after_clean", clean_d, 1'b0);
    end

    // 6: press then release through the downstream latch
    raw_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check_bit("latch_press_en", en_pulse, i == 6);
      if (i >= 6) check_bit("latch_press_q", latch_q, 1'b1);
      check_bit("latch_press_qbar", latch_qbar, ~latch_q);
    end
    raw_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      check_bit("latch_rel_en", en_pulse, i == 6);
      check_bit("latch_rel_q", latch_q, i < 6);
      check_bit("latch_rel_qbar", latch_qbar, ~latch_q);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
